// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file access controller.
// Describes the 5-bit register address space and one writeback record.
package rf_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } rf_wb_t;
endpackage

// File: rtl/wb_fifo_cam.sv
// Writeback FIFO with two associative lookup ports.
// Each lookup returns the youngest pending entry for a register.
module wb_fifo_cam
   import rf_pkg::*;
#(
   parameter int XLEN     = rf_pkg::XLEN,
   parameter int WB_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [REG_AW-1:0] push_rd,
   input  logic [XLEN-1:0]   push_data,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output logic [REG_AW-1:0] head_rd,
   output logic [XLEN-1:0]   head_data,
   input  logic [REG_AW-1:0] la_rs,
   output logic              la_hit,
   output logic [XLEN-1:0]   la_data,
   input  logic [REG_AW-1:0] lb_rs,
   output logic              lb_hit,
   output logic [XLEN-1:0]   lb_data
);
   localparam int PW = $clog2(WB_DEPTH);

   logic [REG_AW-1:0] rd_mem   [WB_DEPTH];
   logic [XLEN-1:0]   data_mem [WB_DEPTH];
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [PW:0]       count;
   logic              do_push;
   logic              do_pop;

   assign full      = (count == (PW+1)'(WB_DEPTH));
   assign empty     = (count == '0);
   assign do_push   = push & ~full;
   assign do_pop    = pop & ~empty;
   assign head_rd   = rd_mem[head];
   assign head_data = data_mem[head];

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) tail <= tail + 1'b1;
         if (do_pop)  head <= head + 1'b1;
         if (do_push & ~do_pop)      count <= count + 1'b1;
         else if (~do_push & do_pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         rd_mem[tail]   <= push_rd;
         data_mem[tail] <= push_data;
      end
   end

   // Walk from oldest (tail-count) to youngest (tail-1) so the youngest hit wins.
   function automatic logic [XLEN:0] lookup(input logic [REG_AW-1:0] rs);
      logic [XLEN:0] res;
      logic [PW-1:0] idx;
      res = '0;
      idx = '0;
      for (int k = WB_DEPTH; k >= 1; k--) begin
         idx = tail - PW'(k);
         if (((PW+1)'(k) <= count) && (rd_mem[idx] == rs))
            res = {1'b1, data_mem[idx]};
      end
      return res;
   endfunction

   always_comb begin
      {la_hit, la_data} = lookup(la_rs);
      {lb_hit, lb_data} = lookup(lb_rs);
   end
endmodule

// File: rtl/rf_access_ctrl.sv
// Requester-side controller for the 2R/1W register file: operand reads with
// x0 and writeback forwarding, writebacks buffered and drained one per cycle.
module rf_access_ctrl
   import rf_pkg::*;
#(
   parameter int XLEN     = rf_pkg::XLEN,
   parameter int WB_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [REG_AW-1:0] rd_rs1,
   input  logic [REG_AW-1:0] rd_rs2,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_a,
   output logic [XLEN-1:0]   rsp_b,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic [REG_AW-1:0] rf_ra,
   output logic [REG_AW-1:0] rf_rb,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_rd,
   output logic [XLEN-1:0]   rf_di,
   input  logic [XLEN-1:0]   rf_qa,
   input  logic [XLEN-1:0]   rf_qb,
   output logic              idle
);
   logic            rd_accept;
   logic            wb_accept;
   logic            fifo_push;
   logic            fifo_full;
   logic            fifo_empty;
   logic            hit_a;
   logic            hit_b;
   logic [XLEN-1:0] fwd_a;
   logic [XLEN-1:0] fwd_b;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;

   assign rd_ready  = ~rsp_valid | rsp_ready;
   assign rd_accept = rd_valid & rd_ready;
   assign wb_ready  = ~fifo_full;
   assign wb_accept = wb_valid & wb_ready;
   assign fifo_push = wb_accept & (wb_rd != REG_X0);
   assign rf_ra     = rd_rs1;
   assign rf_rb     = rd_rs2;
   // Draining stops while reset is held so discarded writes never reach the file.
   assign rf_we     = ~fifo_empty & ~rst;
   assign idle      = fifo_empty & ~rsp_valid;

   wb_fifo_cam #(.XLEN(XLEN), .WB_DEPTH(WB_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_rd   (wb_rd),
      .push_data (wb_data),
      .pop       (rf_we),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head_rd   (rf_rd),
      .head_data (rf_di),
      .la_rs     (rd_rs1),
      .la_hit    (hit_a),
      .la_data   (fwd_a),
      .lb_rs     (rd_rs2),
      .lb_hit    (hit_b),
      .lb_data   (fwd_b)
   );

   function automatic logic [XLEN-1:0] select_operand(
      input logic [REG_AW-1:0] rs,
      input logic              hit,
      input logic [XLEN-1:0]   fwd,
      input logic [XLEN-1:0]   q
   );
      if (rs == REG_X0)                    return '0;
      else if (wb_accept && (wb_rd == rs)) return wb_data;
      else if (hit)                        return fwd;
      else                                 return q;
   endfunction

   always_comb begin
      op_a = select_operand(rd_rs1, hit_a, fwd_a, rf_qa);
      op_b = select_operand(rd_rs2, hit_b, fwd_b, rf_qb);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_a     <= '0;
         rsp_b     <= '0;
      end else if (rd_accept) begin
         rsp_valid <= 1'b1;
         rsp_a     <= op_a;
         rsp_b     <= op_b;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rf_access_ctrl.sv
// Randomized bench for rf_access_ctrl against a queue-based architectural model;
// the bench also plays the role of the external register file.
module tb_rf_access_ctrl;
   import rf_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_valid, rd_ready, rsp_valid, rsp_ready;
   logic [4:0]  rd_rs1, rd_rs2, wb_rd, rf_ra, rf_rb, rf_rd;
   logic [31:0] rsp_a, rsp_b, wb_data, rf_di, rf_qa, rf_qb;
   logic        wb_valid, wb_ready, rf_we, idle;

   logic [31:0] rf_mem  [32];
   logic [31:0] ref_mem [32];
   rf_wb_t      ref_q [$];
   logic        exp_valid;
   logic [31:0] exp_a, exp_b;

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   rf_access_ctrl #(.XLEN(32), .WB_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_rs1(rd_rs1), .rd_rs2(rd_rs2),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_we(rf_we), .rf_rd(rf_rd), .rf_di(rf_di),
      .rf_qa(rf_qa), .rf_qb(rf_qb), .idle(idle)
   );

   assign rf_qa = rf_mem[rf_ra];
   assign rf_qb = rf_mem[rf_rb];
   always @(posedge clk) if (rf_we === 1'b1) rf_mem[rf_rd] <= rf_di;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_compared++;
      if (got !== want) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic logic [31:0] model_operand(input logic [4:0] rs, input logic wb_acc,
                                                 input logic [4:0] wrd, input logic [31:0] wd);
      if (rs == 5'd0) return 32'd0;
      if (wb_acc && wrd == rs) return wd;
      for (int i = ref_q.size() - 1; i >= 0; i--)
         if (ref_q[i].rd == rs) return ref_q[i].data;
      return ref_mem[rs];
   endfunction

   // One clock cycle: drive, check against the model, then advance the model past the edge.
   task automatic applyStimulus(input logic r, input logic rv, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic rr, input logic wv,
                                input logic [4:0] wrd, input logic [31:0] wd);
      logic        exp_rd_ready, exp_wb_ready, exp_we, acc_rd, acc_wb;
      logic [31:0] na, nb;
      @(negedge clk);
      rst = r; rd_valid = rv; rd_rs1 = rs1; rd_rs2 = rs2; rsp_ready = rr;
      wb_valid = wv; wb_rd = wrd; wb_data = wd;
      #1;
      exp_rd_ready = !exp_valid || rr;
      exp_wb_ready = ref_q.size() < DEPTH;
      exp_we       = !r && ref_q.size() > 0;
      checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
      checkOutput("rsp_a", rsp_a, exp_a);
      checkOutput("rsp_b", rsp_b, exp_b);
      checkOutput("rd_ready", {31'd0, rd_ready}, {31'd0, exp_rd_ready});
      checkOutput("wb_ready", {31'd0, wb_ready}, {31'd0, exp_wb_ready});
      checkOutput("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
      checkOutput("idle", {31'd0, idle}, {31'd0, (ref_q.size() == 0) && !exp_valid});
      checkOutput("rf_ra", {27'd0, rf_ra}, {27'd0, rs1});
      if (exp_we) begin
         checkOutput("rf_rd", {27'd0, rf_rd}, {27'd0, ref_q[0].rd});
         checkOutput("rf_di", rf_di, ref_q[0].data);
      end
      acc_rd = rv && exp_rd_ready;
      acc_wb = wv && exp_wb_ready;
      na = model_operand(rs1, acc_wb, wrd, wd);
      nb = model_operand(rs2, acc_wb, wrd, wd);
      @(posedge clk);
      #1;
      if (r) begin
         ref_q.delete();
         exp_valid = 1'b0; exp_a = '0; exp_b = '0;
      end else begin
         if (acc_rd) begin
            exp_valid = 1'b1; exp_a = na; exp_b = nb;
         end else if (rr) begin
            exp_valid = 1'b0;
         end
         if (ref_q.size() > 0) begin
            ref_mem[ref_q[0].rd] = ref_q[0].data;
            void'(ref_q.pop_front());
         end
         if (acc_wb && wrd != 5'd0) ref_q.push_back('{rd: wrd, data: wd});
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf_mem[i]  = $urandom;
         ref_mem[i] = rf_mem[i];
      end
      rf_mem[5] = 32'h11; ref_mem[5] = 32'h11;

      rst = 1'b1; rd_valid = 0; rd_rs1 = 0; rd_rs2 = 0; rsp_ready = 1;
      wb_valid = 0; wb_rd = 0; wb_data = 0;
      repeat (2) @(posedge clk);
      #1;
      exp_valid = 1'b0; exp_a = '0; exp_b = '0;

      applyStimulus(0, 1, 5, 0, 1, 0, 0, 0);
      applyStimulus(0, 1, 7, 0, 1, 1, 7, 32'hAAAA);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 3, 32'd1);
      applyStimulus(0, 0, 0, 0, 1, 1, 3, 32'd2);
      applyStimulus(0, 0, 0, 0, 1, 1, 3, 32'd3);
      applyStimulus(0, 1, 3, 3, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);

      applyStimulus(0, 1, 5, 7, 0, 0, 0, 0);
      repeat (3) applyStimulus(0, 1, 3, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 3, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);

      applyStimulus(0, 0, 0, 0, 1, 1, 0, 32'hFFFF);
      applyStimulus(0, 1, 0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 9, 32'h1234);
      applyStimulus(0, 1, 9, 9, 0, 1, 10, 32'h5678);
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
      repeat (3) applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);

      for (int n = 0; n < 400; n++)
         applyStimulus(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                       5'($urandom_range(0, 7)), $urandom);

      repeat (DEPTH + 2) applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 1; i < 32; i++)
         checkOutput($sformatf("regfile_x%0d", i), rf_mem[i], ref_mem[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
